// File: rtl/wb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : wb_uart_tx
// Purpose  : Wishbone responder with a byte TX FIFO feeding an 8N1 UART
//            serializer. Registers: DATA (0), STATUS (1), DIV (2).
// Revision : 1.0 - initial release
// ============================================================================
module wb_uart_tx #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_RESET  = 104,
    parameter int DIV_WIDTH  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [3:0]  wb_adr,
    input  logic [31:0] wb_dat_c,
    output logic [31:0] wb_dat_p,
    output logic        wb_ack,
    output logic        tx
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_lw = c_aw + 1;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_data  = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;

    localparam logic [c_lw-1:0]      c_full_level = c_lw'(FIFO_DEPTH);
    localparam logic [DIV_WIDTH-1:0] c_div_reset  = DIV_WIDTH'(DIV_RESET);

    // FIFO storage and bookkeeping
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]      r_wr_ptr;
    logic [c_aw-1:0]      r_rd_ptr;
    logic [c_lw-1:0]      r_level;

    // Register file
    logic                 r_overflow;
    logic [DIV_WIDTH-1:0] r_div;

    // Serializer
    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [DIV_WIDTH-1:0] r_div_lat;
    logic [DIV_WIDTH-1:0] r_baud_cnt;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_shift;
    logic [7:0]           w_shift_next;
    logic                 w_tx_next;

    // Handshake / control wires
    logic                 w_access;
    logic                 w_push_req;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_baud_tick;
    logic [31:0]          w_rd_data;
    logic                 w_unused;

    // A transaction is taken only on the first cycle of a strobe (ack low).
    assign w_access    = wb_stb & ~wb_ack;
    assign w_push_req  = w_access & wb_we & (wb_adr == 4'd0);
    assign w_full      = (r_level == c_full_level);
    assign w_empty     = (r_level == '0);
    assign w_push      = w_push_req & ~w_full;
    assign w_pop       = (r_state == c_idle) & ~w_empty;
    assign w_baud_tick = (r_baud_cnt == (r_div_lat - DIV_WIDTH'(1)));
    assign w_unused    = ^wb_dat_c;

    // Read-data multiplexer, evaluated on the pre-edge register values
    always_comb begin
        w_rd_data = '0;
        case (wb_adr)
            4'd1: begin
                w_rd_data[0]          = w_full;
                w_rd_data[1]          = w_empty;
                w_rd_data[2]          = (r_state != c_idle);
                w_rd_data[3]          = r_overflow;
                w_rd_data[8 +: c_lw]  = r_level;
            end
            4'd2: begin
                w_rd_data[DIV_WIDTH-1:0] = r_div;
            end
            default: begin
                w_rd_data = '0;
            end
        endcase
    end

    // Bus handshake, read-data register and control/status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack     <= 1'b0;
            wb_dat_p   <= '0;
            r_div      <= c_div_reset;
            r_overflow <= 1'b0;
        end else begin
            wb_ack   <= w_access;
            wb_dat_p <= (w_access & ~wb_we) ? w_rd_data : 32'd0;
            if (w_access & wb_we) begin
                if ((wb_adr == 4'd1) && wb_dat_c[3]) begin
                    r_overflow <= 1'b0;
                end
                if (wb_adr == 4'd2) begin
                    r_div <= wb_dat_c[DIV_WIDTH-1:0];
                end
            end
            // Fullness is judged before any same-cycle pop, so a push into a
            // full FIFO is dropped even if the serializer is draining it.
            if (w_push_req & w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FIFO storage write port (contents need no reset)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wb_dat_c[7:0];
        end
    end

    // FIFO pointers and level counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lw'(1);
                2'b01:   r_level <= r_level - c_lw'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Serializer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Serializer next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:  if (!w_empty)                         w_state_next = c_start;
            c_start: if (w_baud_tick)                      w_state_next = c_data;
            c_data:  if (w_baud_tick && (r_bit_cnt == 3'd7)) w_state_next = c_stop;
            c_stop:  if (w_baud_tick)                      w_state_next = c_idle;
            default:                                       w_state_next = c_idle;
        endcase
    end

    // Serializer outputs: next shift contents and next line level, so tx can
    // be registered and change on the same edge as the state
    always_comb begin
        w_shift_next = r_shift;
        if (w_pop) begin
            w_shift_next = r_mem[r_rd_ptr];
        end else if ((r_state == c_data) && w_baud_tick && (r_bit_cnt != 3'd7)) begin
            w_shift_next = {1'b0, r_shift[7:1]};
        end
        w_tx_next = 1'b1;
        case (w_state_next)
            c_start: w_tx_next = 1'b0;
            c_data:  w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    // Serializer datapath: line register, shifter, baud and bit counters
    always_ff @(posedge clk) begin
        if (rst) begin
            tx         <= 1'b1;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_div_lat  <= DIV_WIDTH'(1);
        end else begin
            tx      <= w_tx_next;
            r_shift <= w_shift_next;
            if (w_pop) begin
                // Divisor is frozen per frame; zero behaves as one.
                r_div_lat  <= (r_div == '0) ? DIV_WIDTH'(1) : r_div;
                r_baud_cnt <= '0;
                r_bit_cnt  <= '0;
            end else if (r_state != c_idle) begin
                if (w_baud_tick) begin
                    r_baud_cnt <= '0;
                    if (r_state == c_data) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end else begin
                    r_baud_cnt <= r_baud_cnt + DIV_WIDTH'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_uart_tx
// Purpose  : Self-checking bench for wb_uart_tx. Bus reads push expected data
//            into a scoreboard queue; a monitor pops and compares on ack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_uart_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_adr = 4'd0;
    logic [31:0] wb_dat_c = 32'd0;
    logic [31:0] wb_dat_p;
    logic        wb_ack;
    logic        tx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          chk;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    bit   mon_en   = 1'b0;
    logic prev_ack = 1'b0;

    wb_uart_tx #(
        .FIFO_DEPTH (16),
        .DIV_RESET  (104),
        .DIV_WIDTH  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_adr   (wb_adr),
        .wb_dat_c (wb_dat_c),
        .wb_dat_p (wb_dat_p),
        .wb_ack   (wb_ack),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus transaction; ack must arrive exactly one cycle after stb.
    task automatic bus(input bit we, input logic [3:0] adr, input logic [31:0] dat,
                       input bit chk, input logic [31:0] exp, input string name);
        exp_t e;
        @(posedge clk); #1;
        check({name, "_ack_low_before"}, {31'd0, wb_ack}, 32'd0);
        e.chk = chk; e.val = exp; e.name = name;
        q.push_back(e);
        wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_c = dat;
        @(posedge clk); #1;
        check({name, "_ack"}, {31'd0, wb_ack}, 32'd1);
        wb_stb = 1'b0; wb_we = 1'b0; wb_adr = 4'd0; wb_dat_c = 32'd0;
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] dat, input string name);
        bus(1'b1, adr, dat, 1'b0, 32'd0, name);
    endtask

    task automatic rd(input logic [3:0] adr, input logic [31:0] exp, input string name);
        bus(1'b0, adr, 32'd0, 1'b1, exp, name);
    endtask

    // Scoreboard monitor: compares read data whenever the DUT acks.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (wb_ack === 1'b1) begin
                check("ack_single_cycle", {31'd0, prev_ack}, 32'd0);
                if (q.size() == 0) begin
                    check("ack_without_request", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    if (e.chk) check(e.name, wb_dat_p, e.val);
                end
            end else begin
                check("dat_p_zero_without_ack", wb_dat_p, 32'd0);
            end
        end
        prev_ack = wb_ack;
    end

    // Expected 8N1 line level at cycle p (0..) of a frame with divisor d.
    function automatic logic frame_bit(input logic [7:0] b, input int p, input int d);
        int idx;
        idx = p / d;
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got 1 expected 0");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] t3_bytes [3];
        bit   found;
        bit   seen_low;
        t3_bytes[0] = 8'hA5; t3_bytes[1] = 8'h0F; t3_bytes[2] = 8'hFF;

        // ---- 1: reset values ----
        do_reset();
        check("t1_tx_reset", {31'd0, tx}, 32'd1);
        check("t1_ack_reset", {31'd0, wb_ack}, 32'd0);
        check("t1_datp_reset", wb_dat_p, 32'd0);
        mon_en = 1'b1;
        rd(4'd1, 32'h0000_0002, "t1_status");
        rd(4'd2, 32'd104, "t1_div");
        rd(4'd0, 32'd0, "t1_data_read");
        check("t1_tx_idle", {31'd0, tx}, 32'd1);

        // ---- 2: single frame, DIV=4, byte 0x55 ----
        wr(4'd2, 32'd4, "t2_div");
        wr(4'd0, 32'h55, "t2_data");
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    @(posedge clk); #1;
                    check($sformatf("t2_tx_%0d", k), {31'd0, tx}, {31'd0, frame_bit(8'h55, k, 4)});
                end
            end
            begin
                repeat (6) @(posedge clk);
                rd(4'd1, 32'h0000_0006, "t2_status_busy");
            end
        join
        rd(4'd1, 32'h0000_0002, "t2_status_done");

        // ---- 3: three back-to-back frames, DIV=2 ----
        wr(4'd2, 32'd2, "t3_div");
        fork
            begin
                found = 1'b0;
                for (int t = 0; t < 20 && !found; t++) begin
                    @(posedge clk); #1;
                    if (tx === 1'b0) found = 1'b1;
                end
                check("t3_first_start_seen", {31'd0, found}, 32'd1);
                for (int c = 0; c < 63; c++) begin
                    if (c > 0) begin
                        @(posedge clk); #1;
                    end
                    check($sformatf("t3_tx_%0d", c), {31'd0, tx},
                          {31'd0, ((c % 21) == 20) ? 1'b1 : frame_bit(t3_bytes[c / 21], c % 21, 2)});
                end
            end
            begin
                wr(4'd0, 32'hA5, "t3_push0");
                wr(4'd0, 32'h0F, "t3_push1");
                wr(4'd0, 32'hFF, "t3_push2");
                rd(4'd1, 32'h0000_0204, "t3_status_level2");
            end
        join
        rd(4'd1, 32'h0000_0002, "t3_status_end");

        // ---- 4: fill, overflow, clear ----
        wr(4'd2, 32'd1000, "t4_div");
        for (int i = 0; i < 17; i++) wr(4'd0, 32'(i), "t4_push");
        rd(4'd1, 32'h0000_1005, "t4_status_full");
        wr(4'd0, 32'h11, "t4_push_over0");
        wr(4'd0, 32'h12, "t4_push_over1");
        rd(4'd1, 32'h0000_100D, "t4_status_overflow");
        wr(4'd1, 32'h0000_0008, "t4_clear_ovf");
        rd(4'd1, 32'h0000_1005, "t4_status_cleared");

        // ---- 5: unmapped address ----
        wr(4'd7, 32'hDEADBEEF, "t5_wr_unmapped");
        rd(4'd7, 32'd0, "t5_rd_unmapped");
        rd(4'd2, 32'd1000, "t5_div_unchanged");

        // ---- 6: reset mid data bit with 5 bytes queued ----
        do_reset();
        wr(4'd2, 32'd4, "t6_div");
        for (int i = 0; i < 6; i++) wr(4'd0, 32'(8'h80 + i), "t6_push");
        check("t6_tx_mid_frame_low", {31'd0, tx}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_tx_after_reset", {31'd0, tx}, 32'd1);
        rd(4'd1, 32'h0000_0002, "t6_status_empty");
        rd(4'd2, 32'd104, "t6_div_reset");
        seen_low = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) seen_low = 1'b1;
        end
        check("t6_no_frame_after_reset", {31'd0, seen_low}, 32'd0);

        // ---- drain scoreboard ----
        for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
        check("scoreboard_empty", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
